ddr_read_phase_cal: RTL and testbench

- Calibrates the DDR3 read-capture clock phase by driving the PLL clocking block's step-based phase interface (phase_step / phase_updn).
- Sweeps all 8 PLL phase positions and runs an external read-compare test at each one.
- Finds the longest circular passing window, moves the read clock to the centre of that window, and reports the result.
- Sits between the DDR3 init sequencer, which starts it, and the clocking block. It shares the clocking block's clock and reset domain.

---
 rtl/ddr_read_phase_cal.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ddr_read_phase_cal.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_phase_cal.sv
`timescale 1ns/1ps
// DDR3 read-capture phase calibration.
// Sweeps the 8 PLL phase positions, runs one read-compare test per phase,
// picks the centre of the longest circular passing window and steps the
// PLL there. cur_phase mirrors the clocking block's own phase tracker.
module ddr_read_phase_cal #(
    parameter int PHASE_STEPS       = 8,
    parameter int SETTLE_CYCLES     = 64,
    parameter int STEP_PULSE_CYCLES = 4,
    parameter int TEST_TIMEOUT      = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pll_locked,
    output logic       phase_step,
    output logic       phase_updn,
    output logic       test_req,
    input  logic       test_done,
    input  logic       test_pass,
    output logic       busy,
    output logic       done,
    output logic       cal_ok,
    output logic       error,
    output logic [2:0] best_phase,
    output logic [7:0] pass_map,
    output logic [2:0] cur_phase
);

    localparam logic [2:0]  LAST_IDX   = 3'(PHASE_STEPS - 1);
    localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TEST_END   = 16'(TEST_TIMEOUT - 1);
    localparam logic [15:0] HI_END     = 16'(STEP_PULSE_CYCLES);
    localparam logic [15:0] LO_END     = 16'(STEP_PULSE_CYCLES - 1);
    localparam logic [15:0] EVAL_END   = 16'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_LOCK, S_SETTLE, S_TEST, S_STEP_HI,
        S_STEP_LO, S_EVAL, S_MOVE, S_DONE, S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  sweep_q, sweep_d;
    logic [2:0]  origin_q, origin_d;
    logic [2:0]  cur_q, cur_d;
    logic [2:0]  target_q, target_d;
    logic [2:0]  best_q, best_d;
    logic [7:0]  map_q, map_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        step_q, step_d;
    logic        updn_q, updn_d;
    logic        moving_q, moving_d;

    logic [2:0]  up_dist, down_dist, best_calc;
    logic        test_fin, active;

    // Centre of the longest circular run of ones; lowest start index wins ties.
    function automatic logic [2:0] calc_best(input logic [7:0] m);
        int   bl, bs, len;
        logic run;
        bl = 0;
        bs = 0;
        if (m == 8'hFF) return 3'd4;
        for (int s = 0; s < 8; s++) begin
            if (m[3'(s)] && !m[3'(s + 7)]) begin
                len = 0;
                run = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    if (run && m[3'(s + k)]) len++;
                    else run = 1'b0;
                end
                if (len > bl) begin
                    bl = len;
                    bs = s;
                end
            end
        end
        return 3'(bs + (bl - 1) / 2);
    endfunction

    assign up_dist   = target_q - cur_q;
    assign down_dist = cur_q - target_q;
    assign best_calc = calc_best(map_q);
    assign active    = !(state_q inside {S_IDLE, S_WAIT_LOCK, S_DONE, S_FAIL});

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_d  = sweep_q;
        origin_d = origin_q;
        cur_d    = cur_q;
        target_d = target_q;
        best_d   = best_q;
        map_d    = map_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ok_d     = ok_q;
        err_d    = err_q;
        req_d    = req_q;
        step_d   = step_q;
        updn_d   = updn_q;
        moving_d = moving_q;
        test_fin = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d  = S_WAIT_LOCK;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    ok_d     = 1'b0;
                    err_d    = 1'b0;
                    map_d    = 8'h00;
                    origin_d = cur_q;
                    sweep_d  = 3'd0;
                    moving_d = 1'b0;
                end
            end
            S_WAIT_LOCK: begin
                if (pll_locked) begin
                    state_d = S_SETTLE;
                    cnt_d   = 16'd0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == SETTLE_END) begin
                    cnt_d = 16'd0;
                    if (moving_q) begin
                        state_d = S_MOVE;
                    end else begin
                        state_d = S_TEST;
                        req_d   = 1'b1;
                    end
                end
            end
            S_TEST: begin
                cnt_d = cnt_q + 16'd1;
                if (test_done && req_q) begin
                    map_d[cur_q] = test_pass;
                    test_fin     = 1'b1;
                end else if (cnt_q == TEST_END) begin
                    map_d[cur_q] = 1'b0;
                    test_fin     = 1'b1;
                end
                if (test_fin) begin
                    req_d = 1'b0;
                    cnt_d = 16'd0;
                    if (sweep_q != LAST_IDX) begin
                        state_d = S_STEP_HI;
                        updn_d  = 1'b1;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_STEP_HI: begin
                cnt_d  = cnt_q + 16'd1;
                step_d = 1'b1;
                // The rising edge of phase_step and the tracker update share a clock edge.
                if (cnt_q == 16'd0) cur_d = updn_q ? cur_q + 3'd1 : cur_q - 3'd1;
                if (cnt_q == HI_END) begin
                    step_d  = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = S_STEP_LO;
                end
            end
            S_STEP_LO: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == LO_END) begin
                    cnt_d   = 16'd0;
                    state_d = S_SETTLE;
                    if (!moving_q) sweep_d = sweep_q + 3'd1;
                end
            end
            S_EVAL: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == EVAL_END) begin
                    cnt_d    = 16'd0;
                    state_d  = S_MOVE;
                    moving_d = 1'b1;
                    if (map_q == 8'h00) begin
                        ok_d     = 1'b0;
                        err_d    = 1'b1;
                        target_d = origin_q;
                    end else begin
                        ok_d     = 1'b1;
                        target_d = best_calc;
                    end
                end
            end
            S_MOVE: begin
                if (cur_q == target_q) begin
                    best_d  = target_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = err_q ? S_FAIL : S_DONE;
                end else begin
                    updn_d  = (up_dist <= down_dist);
                    cnt_d   = 16'd0;
                    state_d = S_STEP_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Lock loss aborts: no new step edge, the tracker keeps what was already issued.
        if (active && !pll_locked) begin
            state_d = S_FAIL;
            cnt_d   = 16'd0;
            cur_d   = cur_q;
            map_d   = map_q;
            err_d   = 1'b1;
            done_d  = 1'b1;
            ok_d    = 1'b0;
            busy_d  = 1'b0;
            req_d   = 1'b0;
            step_d  = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously with the clocking block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            sweep_q  <= 3'd0;
            origin_q <= 3'd0;
            cur_q    <= 3'd0;
            target_q <= 3'd0;
            best_q   <= 3'd0;
            map_q    <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            step_q   <= 1'b0;
            updn_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sweep_q  <= sweep_d;
            origin_q <= origin_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            best_q   <= best_d;
            map_q    <= map_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            req_q    <= req_d;
            step_q   <= step_d;
            updn_q   <= updn_d;
            moving_q <= moving_d;
        end
    end

    assign phase_step = step_q;
    assign phase_updn = updn_q;
    assign test_req   = req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cal_ok     = ok_q;
    assign error      = err_q;
    assign best_phase = best_q;
    assign pass_map   = map_q;
    assign cur_phase  = cur_q;

endmodule

// File: tb/tb_ddr_read_phase_cal.sv
`timescale 1ns/1ps
// Bench for ddr_read_phase_cal: a read-compare responder driven by an
// independent phase tracker, and a scoreboard of expected calibration results.
module tb_ddr_read_phase_cal;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       pll_locked = 1'b0;
    logic       test_done = 1'b0;
    logic       test_pass = 1'b0;
    logic       phase_step, phase_updn, test_req, busy, done, cal_ok, error;
    logic [2:0] best_phase, cur_phase;
    logic [7:0] pass_map;

    localparam int BUDGET = 20000;

    always #5 clk = ~clk;

    ddr_read_phase_cal dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pll_locked (pll_locked),
        .phase_step (phase_step),
        .phase_updn (phase_updn),
        .test_req   (test_req),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .busy       (busy),
        .done       (done),
        .cal_ok     (cal_ok),
        .error      (error),
        .best_phase (best_phase),
        .pass_map   (pass_map),
        .cur_phase  (cur_phase)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Clocking-block phase tracker: one count per rising edge of phase_step.
    logic [2:0] model_phase = 3'd0;
    int         step_cnt = 0;
    always @(posedge phase_step or negedge rst_n) begin
        if (!rst_n) begin
            model_phase <= 3'd0;
        end else begin
            model_phase <= phase_updn ? model_phase + 3'd1 : model_phase - 3'd1;
            step_cnt    <= step_cnt + 1;
        end
    end

    // Read-compare responder: answers each test_req after a short random delay.
    logic [7:0] resp_map = 8'h00;
    int         silent = -1;
    initial begin
        int resp_wait;
        bit served;
        resp_wait = -1;
        served = 1'b0;
        forever begin
            @(negedge clk);
            test_done = 1'b0;
            if (!rst_n || !test_req) begin
                resp_wait = -1;
                served = 1'b0;
            end else if (!served) begin
                if (resp_wait < 0) begin
                    resp_wait = int'($urandom_range(4, 1));
                end else if (resp_wait == 0) begin
                    if (int'(model_phase) != silent) begin
                        test_done = 1'b1;
                        test_pass = resp_map[model_phase];
                        served = 1'b1;
                    end
                end else begin
                    resp_wait--;
                end
            end
        end
    end

    typedef struct {
        logic [7:0] map;
        logic [2:0] best;
        logic       ok;
        logic       err;
        int         steps;
    } exp_t;
    exp_t sb_q[$];

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(output int s0);
        @(negedge clk);
        start = 1'b1;
        s0 = step_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One complete calibration; expectations are queued before start and
    // popped when done rises.
    task automatic run_cal(input logic [7:0] map, input int silent_ph, input logic [7:0] exp_map,
                           input logic [2:0] exp_best, input logic exp_ok, input logic exp_err,
                           input bit poke, input bit late_lock);
        exp_t e;
        int   s0, org, endp, d, req_hi;
        bit   poked, got;
        logic [2:0] tgt;
        resp_map = map;
        silent = silent_ph;
        org = int'(model_phase);
        endp = (org + 7) % 8;
        tgt = exp_err ? 3'(org) : exp_best;
        d = (int'(tgt) - endp + 8) % 8;
        e.map = exp_map;
        e.best = tgt;
        e.ok = exp_ok;
        e.err = exp_err;
        e.steps = 7 + ((d <= 4) ? d : 8 - d);
        sb_q.push_back(e);
        pll_locked = !late_lock;
        pulse_start(s0);
        if (late_lock) begin
            repeat (20) @(negedge clk);
            chk("wait_lock_busy", 32'(busy), 32'd1);
            chk("wait_lock_no_req", 32'(test_req), 32'd0);
            pll_locked = 1'b1;
        end
        req_hi = 0;
        poked = 1'b0;
        got = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (start) begin
                start = 1'b0;
                chk("start_ignored_busy", 32'(busy), 32'd1);
            end else if (poke && !poked && (step_cnt - s0) == 2) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (test_req && int'(model_phase) == silent) req_hi++;
        end
        start = 1'b0;
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("pass_map", 32'(pass_map), 32'(e.map));
            chk("best_phase", 32'(best_phase), 32'(e.best));
            chk("cal_ok", 32'(cal_ok), 32'(e.ok));
            chk("error", 32'(error), 32'(e.err));
            chk("cur_phase", 32'(cur_phase), 32'(e.best));
            chk("pll_phase", 32'(model_phase), 32'(e.best));
            chk("step_count", 32'(step_cnt - s0), 32'(e.steps));
            chk("busy_end", 32'(busy), 32'd0);
            chk("req_step_idle", 32'({test_req, phase_step}), 32'd0);
            if (silent_ph >= 0) chk("timeout_len", 32'(req_hi), 32'd1024);
        end
    endtask

    initial begin
        int s0;
        bit seen;

        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cal_ok", 32'(cal_ok), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_best", 32'(best_phase), 32'd0);
        chk("rst_map", 32'(pass_map), 32'd0);
        chk("rst_cur", 32'(cur_phase), 32'd0);
        chk("rst_req_step", 32'({test_req, phase_step, phase_updn}), 32'd0);

        // Centred window, late lock, start poked mid-sweep
        run_cal(8'h3C, -1, 8'h3C, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        // Window wrapping across phase 0
        do_reset();
        run_cal(8'hC3, -1, 8'hC3, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        // No passing phase: return to origin and report failure
        do_reset();
        run_cal(8'h00, -1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Every phase passes
        do_reset();
        run_cal(8'hFF, -1, 8'hFF, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        // Silent responder at phase 5 forces a timeout
        do_reset();
        run_cal(8'hFF, 5, 8'hDF, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Lock lost during the third step pulse
        do_reset();
        resp_map = 8'h3C;
        silent = -1;
        pll_locked = 1'b1;
        pulse_start(s0);
        seen = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if ((step_cnt - s0) == 3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("third_step_seen", 32'(seen), 32'd1);
        pll_locked = 1'b0;
        @(negedge clk);
        chk("lol_step", 32'(phase_step), 32'd0);
        chk("lol_req", 32'(test_req), 32'd0);
        chk("lol_flags", 32'({done, error, cal_ok, busy}), 32'b1100);
        chk("lol_cur", 32'(cur_phase), 32'd3);
        repeat (20) @(negedge clk);
        chk("lol_no_more_steps", 32'(step_cnt - s0), 32'd3);
        run_cal(8'h3C, -1, 8'h3C, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a settle interval
        do_reset();
        resp_map = 8'hFF;
        pll_locked = 1'b1;
        pulse_start(s0);
        seen = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if ((step_cnt - s0) == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("second_step_seen", 32'(seen), 32'd1);
        repeat (10) @(negedge clk);
        chk("pre_rst_cur", 32'(cur_phase), 32'd2);
        chk("pre_rst_map", 32'(pass_map), 32'h03);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_cur", 32'(cur_phase), 32'd0);
        chk("async_rst_map", 32'(pass_map), 32'd0);
        chk("async_rst_outs", 32'({test_req, phase_step, done, error, cal_ok}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cal(8'hFF, -1, 8'hFF, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
